// File: rtl/bisr_sched_pkg.sv
// Shared definitions for the BISR test scheduler: controller state encoding,
// default campaign sizing and a field-width helper.
package bisr_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_SCAN  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    localparam int DEF_NUM_PATTERNS = 4;
    localparam int DEF_TIMEOUT      = 64;

    // Width of a field able to hold values 0..n-1, never narrower than one bit.
    function automatic int fld_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bisr_fault_scanner.sv
// Walks the accumulated fault map row-major, one PE per cycle, and hands out
// redundant units to faulty PEs in scan order. Faults beyond the last RU
// raise a sticky repair_fail.
module bisr_fault_scanner
    import bisr_sched_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NUM_RU = 4,
    parameter int CB     = fld_width(COLS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     scan_en,
    input  logic                     invalidate,
    input  logic [ROWS*COLS-1:0]     fault_map,
    output logic                     scan_last,
    output logic [CB*NUM_RU-1:0]     ru_row_mapping,
    output logic [CB*NUM_RU-1:0]     ru_col_mapping,
    output logic [NUM_RU-1:0]        ru_valid,
    output logic                     repair_fail
);

    localparam int NPE = ROWS * COLS;
    localparam int IW  = fld_width(NPE);
    localparam int AW  = fld_width(NUM_RU + 1);

    localparam logic [IW-1:0] IDX_LAST   = IW'(NPE - 1);
    localparam logic [CB-1:0] COL_LAST   = CB'(COLS - 1);
    localparam logic [AW-1:0] ALLOC_FULL = AW'(NUM_RU);

    logic [IW-1:0] scan_idx;
    logic [CB-1:0] scan_row;
    logic [CB-1:0] scan_col;
    logic [AW-1:0] alloc;
    logic          pe_faulty;

    assign pe_faulty = fault_map[scan_idx];
    assign scan_last = (scan_idx == IDX_LAST);

    // Scan position: flat index for the fault map plus row/column for the RU
    // fields; parked at PE 0 whenever the controller is not scanning.
    always_ff @(posedge clk) begin
        if (rst || !scan_en) begin
            scan_idx <= '0;
            scan_row <= '0;
            scan_col <= '0;
        end else begin
            scan_idx <= scan_idx + 1'b1;
            if (scan_col == COL_LAST) begin
                scan_col <= '0;
                scan_row <= scan_row + 1'b1;
            end else begin
                scan_col <= scan_col + 1'b1;
            end
        end
    end

    // RU allocation: the next free RU takes the faulty PE under the scan
    // pointer; once all RUs are used any further fault is unrepairable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            alloc          <= '0;
            ru_row_mapping <= '0;
            ru_col_mapping <= '0;
            ru_valid       <= '0;
            repair_fail    <= 1'b0;
        end else if (invalidate) begin
            ru_valid <= '0;
        end else if (scan_en && pe_faulty) begin
            if (alloc != ALLOC_FULL) begin
                for (int k = 0; k < NUM_RU; k++) begin
                    if (alloc == AW'(k)) begin
                        ru_row_mapping[k*CB +: CB] <= scan_row;
                        ru_col_mapping[k*CB +: CB] <= scan_col;
                        ru_valid[k]                <= 1'b1;
                    end
                end
                alloc <= alloc + 1'b1;
            end else begin
                repair_fail <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bisr_test_scheduler.sv
// BISR test scheduler: holds the systolic array out of matmul use, runs a
// table of self-test-word patterns, accumulates the per-PE fault map and
// finally lets the fault scanner allocate redundant units.
module bisr_test_scheduler
    import bisr_sched_pkg::*;
#(
    parameter  int ROWS         = 4,
    parameter  int COLS         = 4,
    parameter  int WORD_SIZE    = 16,
    parameter  int NUM_RU       = 4,
    parameter  int NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter  int TIMEOUT      = DEF_TIMEOUT,
    localparam int CB           = fld_width(COLS),
    localparam int PB           = fld_width(NUM_PATTERNS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     test_req,
    input  logic                     matmul_busy,
    output logic [PB-1:0]            pat_idx,
    input  logic [WORD_SIZE-1:0]     pat_op1,
    input  logic [WORD_SIZE-1:0]     pat_op2,
    input  logic [WORD_SIZE-1:0]     pat_add,
    input  logic [WORD_SIZE-1:0]     pat_expected,
    output logic [WORD_SIZE-1:0]     STW_mult_op1,
    output logic [WORD_SIZE-1:0]     STW_mult_op2,
    output logic [WORD_SIZE-1:0]     STW_add_op,
    output logic [WORD_SIZE-1:0]     STW_expected,
    output logic                     STW_test_load_en,
    output logic                     STW_start,
    input  logic                     STW_complete,
    input  logic [ROWS*COLS-1:0]     STW_result_mat,
    output logic                     array_hold,
    output logic [ROWS*COLS-1:0]     fault_map,
    output logic [CB*NUM_RU-1:0]     ru_row_mapping,
    output logic [CB*NUM_RU-1:0]     ru_col_mapping,
    output logic [NUM_RU-1:0]        ru_valid,
    output logic                     test_busy,
    output logic                     test_done,
    output logic                     repair_fail,
    output logic                     timeout_err
);

    localparam int TW = fld_width(TIMEOUT);

    localparam logic [PB-1:0] PAT_LAST  = PB'(NUM_PATTERNS - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] wait_cnt;
    logic          accept;
    logic          complete_hit;
    logic          expire;
    logic          scan_last;

    assign accept       = (state == ST_IDLE) && test_req;
    assign complete_hit = (state == ST_WAIT) && STW_complete;
    // Completion in the final counter cycle takes priority over the timeout.
    assign expire       = (state == ST_WAIT) && !STW_complete && (wait_cnt == WAIT_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state selection and state-decoded strobes.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt        = state;
        STW_test_load_en = 1'b0;
        STW_start        = 1'b0;
        array_hold       = 1'b0;
        test_busy        = 1'b1;
        test_done        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                test_busy = 1'b0;
                if (test_req) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                array_hold = 1'b1;
                if (!matmul_busy) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                array_hold       = 1'b1;
                STW_test_load_en = 1'b1;
                state_nxt        = ST_START;
            end
            ST_START: begin
                array_hold = 1'b1;
                STW_start  = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                array_hold = 1'b1;
                if (STW_complete)
                    state_nxt = (pat_idx == PAT_LAST) ? ST_SCAN : ST_LOAD;
                else if (expire)
                    state_nxt = ST_ERR;
            end
            ST_SCAN: begin
                array_hold = 1'b1;
                if (scan_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                test_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                test_done = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pattern registers and pattern index. The ROM word for pat_idx is
    // captured on the edge that ends LOAD, so STW_* are stable from the
    // START strobe through the whole WAIT window.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_idx      <= '0;
            STW_mult_op1 <= '0;
            STW_mult_op2 <= '0;
            STW_add_op   <= '0;
            STW_expected <= '0;
        end else begin
            if (accept)
                pat_idx <= '0;
            else if (complete_hit && (pat_idx != PAT_LAST))
                pat_idx <= pat_idx + 1'b1;
            if (state == ST_LOAD) begin
                STW_mult_op1 <= pat_op1;
                STW_mult_op2 <= pat_op2;
                STW_add_op   <= pat_add;
                STW_expected <= pat_expected;
            end
        end
    end

    // Completion watchdog: cleared by START, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_START)) wait_cnt <= '0;
        else if (state == ST_WAIT)      wait_cnt <= wait_cnt + 1'b1;
    end

    // Campaign results: fault map accumulation and the sticky timeout flag,
    // both held in IDLE until the next accepted request.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            fault_map   <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (complete_hit) fault_map <= fault_map | STW_result_mat;
            if (expire)       timeout_err <= 1'b1;
        end
    end

    bisr_fault_scanner #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .NUM_RU (NUM_RU),
        .CB     (CB)
    ) u_scanner (
        .clk            (clk),
        .rst            (rst),
        .clear          (accept),
        .scan_en        (state == ST_SCAN),
        .invalidate     (state == ST_ERR),
        .fault_map      (fault_map),
        .scan_last      (scan_last),
        .ru_row_mapping (ru_row_mapping),
        .ru_col_mapping (ru_col_mapping),
        .ru_valid       (ru_valid),
        .repair_fail    (repair_fail)
    );

endmodule

// File: tb/tb_bisr_test_scheduler.sv
// Self-checking bench for bisr_test_scheduler: directed campaigns from the
// test plan plus randomized ones, each compared with a campaign-level model
// (latency sums, OR of pattern results, row-major RU allocation list).
module tb_bisr_test_scheduler;

    localparam int ROWS         = 4;
    localparam int COLS         = 4;
    localparam int WORD_SIZE    = 16;
    localparam int NUM_RU       = 4;
    localparam int NUM_PATTERNS = 4;
    localparam int TIMEOUT      = 64;
    localparam int NPE          = ROWS * COLS;
    localparam int CB           = 2;
    localparam int PB           = 2;
    localparam int BUDGET       = 3000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    test_req;
    logic                    matmul_busy;
    logic [PB-1:0]           pat_idx;
    logic [WORD_SIZE-1:0]    pat_op1, pat_op2, pat_add, pat_expected;
    logic [WORD_SIZE-1:0]    STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
    logic                    STW_test_load_en;
    logic                    STW_start;
    logic                    STW_complete;
    logic [NPE-1:0]          STW_result_mat;
    logic                    array_hold;
    logic [NPE-1:0]          fault_map;
    logic [CB*NUM_RU-1:0]    ru_row_mapping, ru_col_mapping;
    logic [NUM_RU-1:0]       ru_valid;
    logic                    test_busy, test_done, repair_fail, timeout_err;

    int checks   = 0;
    int failures = 0;

    // External pattern ROM and per-campaign array behaviour.
    logic [WORD_SIZE-1:0] rom_op1 [NUM_PATTERNS];
    logic [WORD_SIZE-1:0] rom_op2 [NUM_PATTERNS];
    logic [WORD_SIZE-1:0] rom_add [NUM_PATTERNS];
    logic [WORD_SIZE-1:0] rom_exp [NUM_PATTERNS];
    logic [NPE-1:0]       res_tab [NUM_PATTERNS];
    int                   lat_tab [NUM_PATTERNS];   // 0 = completion withheld

    assign pat_op1      = rom_op1[pat_idx];
    assign pat_op2      = rom_op2[pat_idx];
    assign pat_add      = rom_add[pat_idx];
    assign pat_expected = rom_exp[pat_idx];

    always #5 clk = ~clk;

    bisr_test_scheduler #(
        .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WORD_SIZE), .NUM_RU(NUM_RU),
        .NUM_PATTERNS(NUM_PATTERNS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .test_req(test_req), .matmul_busy(matmul_busy),
        .pat_idx(pat_idx), .pat_op1(pat_op1), .pat_op2(pat_op2),
        .pat_add(pat_add), .pat_expected(pat_expected),
        .STW_mult_op1(STW_mult_op1), .STW_mult_op2(STW_mult_op2),
        .STW_add_op(STW_add_op), .STW_expected(STW_expected),
        .STW_test_load_en(STW_test_load_en), .STW_start(STW_start),
        .STW_complete(STW_complete), .STW_result_mat(STW_result_mat),
        .array_hold(array_hold), .fault_map(fault_map),
        .ru_row_mapping(ru_row_mapping), .ru_col_mapping(ru_col_mapping),
        .ru_valid(ru_valid), .test_busy(test_busy), .test_done(test_done),
        .repair_fail(repair_fail), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return 128'({pat_idx, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected,
                     STW_test_load_en, STW_start, array_hold, fault_map,
                     ru_row_mapping, ru_col_mapping, ru_valid,
                     test_busy, test_done, repair_fail, timeout_err});
    endfunction

    task automatic randomize_rom();
        for (int p = 0; p < NUM_PATTERNS; p++) begin
            rom_op1[p] = WORD_SIZE'($urandom);
            rom_op2[p] = WORD_SIZE'($urandom);
            rom_add[p] = WORD_SIZE'($urandom);
            rom_exp[p] = WORD_SIZE'($urandom);
        end
    endtask

    // Runs one campaign starting in IDLE at posedge+1. hold: cycles of
    // matmul_busy after the request; noise: stray test_req/STW_complete
    // that must be ignored; rst_off >= 0: reset that many cycles into SCAN.
    task automatic run_campaign(input string name, input int hold, input bit noise, input int rst_off);
        logic [NPE-1:0]       e_fault;
        logic [CB*NUM_RU-1:0] e_row, e_col;
        logic [NUM_RU-1:0]    e_valid;
        bit                   e_rfail, e_terr;
        int                   base, e_done, e_loads, rst_cycle;
        int                   faulty[$];
        int                   done_cycle, done_len, first_load, loads, last_load, plan, p_cnt;
        bit                   seq_ok, hold_ok, finished;
        logic [3:0]           snap_flags;
        logic [NPE-1:0]       snap_fault;
        logic [CB*NUM_RU-1:0] snap_row, snap_col;
        logic [NUM_RU-1:0]    snap_valid;

        // ---- reference model ----
        e_fault = '0; e_row = '0; e_col = '0; e_valid = '0;
        e_rfail = 1'b0; e_terr = 1'b0; e_loads = 0;
        base = 2 + hold;                        // cycle of the first LOAD
        for (int p = 0; p < NUM_PATTERNS; p++) begin
            e_loads++;
            if (lat_tab[p] == 0) begin
                e_terr = 1'b1;
                break;
            end
            e_fault |= res_tab[p];
            base += 2 + lat_tab[p];
        end
        if (e_terr) begin
            e_done = base + 1 + TIMEOUT + 1;    // START, TIMEOUT WAITs, ERR
        end else begin
            e_done = base + NPE;                // base is now the first SCAN cycle
            for (int i = 0; i < NPE; i++)
                if (e_fault[i]) faulty.push_back(i);
            for (int k = 0; k < faulty.size() && k < NUM_RU; k++) begin
                e_row[k*CB +: CB] = CB'(faulty[k] / COLS);
                e_col[k*CB +: CB] = CB'(faulty[k] % COLS);
                e_valid[k]        = 1'b1;
            end
            e_rfail = (faulty.size() > NUM_RU);
        end
        rst_cycle = (rst_off >= 0) ? base + rst_off : -1;

        // ---- cycle loop ----
        done_cycle = -1; done_len = 0; first_load = -1; loads = 0;
        last_load = -100; plan = -1; p_cnt = 0;
        seq_ok = 1'b1; hold_ok = 1'b1; finished = 1'b0;
        snap_flags = 'x; snap_fault = 'x; snap_row = 'x; snap_col = 'x; snap_valid = 'x;
        for (int n = 0; n < BUDGET; n++) begin
            // observe this cycle's outputs
            if (rst_cycle >= 0 && n == rst_cycle + 1) begin
                check({name, "/reset_all_zero"}, all_outputs(), 128'd0);
                finished = 1'b1;
                break;
            end
            if (STW_test_load_en) begin
                loads++;
                if (first_load < 0) first_load = n;
                last_load = n;
                if (STW_start) seq_ok = 1'b0;
            end
            if (STW_start) begin
                if (last_load != n - 1) seq_ok = 1'b0;
                if (p_cnt < NUM_PATTERNS) begin
                    check({name, "/stw_pattern"},
                          128'({STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}),
                          128'({rom_op1[p_cnt], rom_op2[p_cnt], rom_add[p_cnt], rom_exp[p_cnt]}));
                    plan = (lat_tab[p_cnt] == 0) ? -1 : n + lat_tab[p_cnt];
                end
                p_cnt++;
            end
            if (n >= 1 && n <= hold && (!array_hold || STW_test_load_en)) hold_ok = 1'b0;
            if (test_done) begin
                done_len++;
                if (done_cycle < 0) begin
                    done_cycle = n;
                    snap_flags = {array_hold, test_busy, timeout_err, repair_fail};
                    snap_fault = fault_map;
                    snap_row   = ru_row_mapping;
                    snap_col   = ru_col_mapping;
                    snap_valid = ru_valid;
                end
            end
            if (done_cycle >= 0 && n == done_cycle + 1) begin
                check({name, "/idle_hold_results"},
                      128'({ru_row_mapping, ru_col_mapping, ru_valid, fault_map, test_busy, test_done}),
                      128'({e_row, e_col, e_valid, e_fault, 1'b0, 1'b0}));
                finished = 1'b1;
                break;
            end

            // drive this cycle's inputs
            rst         = (n == rst_cycle);
            test_req    = (n == 0) || (noise && $urandom_range(0, 3) == 0);
            matmul_busy = (n >= 1 && n <= hold) ? 1'b1
                        : (noise && n > hold + 1) ? 1'($urandom) : 1'b0;
            if (n == plan) begin
                STW_complete   = 1'b1;
                STW_result_mat = res_tab[p_cnt - 1];
            end else begin
                STW_complete   = noise && STW_start;
                STW_result_mat = NPE'($urandom);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0; test_req = 1'b0; matmul_busy = 1'b0;
        STW_complete = 1'b0; STW_result_mat = '0;

        check({name, "/terminated"}, 128'(finished), 128'(1'b1));
        if (rst_off < 0) begin
            check({name, "/done_cycle"}, 128'(done_cycle), 128'(e_done));
            check({name, "/done_pulse_len"}, 128'(done_len), 128'(1));
            check({name, "/first_load"}, 128'(first_load), 128'(2 + hold));
            check({name, "/load_count"}, 128'(loads), 128'(e_loads));
            check({name, "/strobe_order"}, 128'(seq_ok), 128'(1'b1));
            if (hold > 0) check({name, "/hold_window"}, 128'(hold_ok), 128'(1'b1));
            check({name, "/done_flags"}, 128'(snap_flags), 128'({1'b0, 1'b1, e_terr, e_rfail}));
            check({name, "/fault_map"}, 128'(snap_fault), 128'(e_fault));
            check({name, "/ru_valid"}, 128'(snap_valid), 128'(e_valid));
            check({name, "/ru_mapping"}, 128'({snap_row, snap_col}), 128'({e_row, e_col}));
        end
    endtask

    task automatic random_latencies();
        for (int p = 0; p < NUM_PATTERNS; p++) lat_tab[p] = int'($urandom_range(1, 8));
    endtask

    task automatic clear_results();
        for (int p = 0; p < NUM_PATTERNS; p++) res_tab[p] = '0;
    endtask

    initial begin
        rst = 1'b1; test_req = 1'b0; matmul_busy = 1'b0;
        STW_complete = 1'b0; STW_result_mat = '0;
        randomize_rom();
        clear_results();
        random_latencies();
        repeat (3) @(posedge clk);
        #1;
        check("reset/all_zero", all_outputs(), 128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean array
        randomize_rom(); clear_results(); random_latencies();
        run_campaign("clean", 0, 1'b0, -1);

        // Two faults: PE(1,2) on pattern 0, PE(3,0) on pattern 2
        randomize_rom(); clear_results(); random_latencies();
        res_tab[0] = NPE'(1) << 6;
        res_tab[2] = NPE'(1) << 12;
        run_campaign("two_faults", 0, 1'b0, -1);

        // Overflow: indices 0,3,5,9,15 spread across patterns
        randomize_rom(); clear_results(); random_latencies();
        res_tab[0] = (NPE'(1) << 0) | (NPE'(1) << 3);
        res_tab[1] = NPE'(1) << 5;
        res_tab[3] = (NPE'(1) << 9) | (NPE'(1) << 15) | (NPE'(1) << 3);
        run_campaign("overflow", 0, 1'b0, -1);

        // Timeout on pattern 1 after a fault seen on pattern 0
        randomize_rom(); clear_results(); random_latencies();
        res_tab[0] = NPE'(1) << 7;
        lat_tab[1] = 0;
        run_campaign("timeout", 0, 1'b0, -1);

        // Completion on the very last allowed WAIT cycle must win
        randomize_rom(); clear_results(); random_latencies();
        lat_tab[2] = TIMEOUT;
        res_tab[2] = NPE'(1) << 10;
        run_campaign("late_complete", 0, 1'b0, -1);

        // Held off by matmul_busy, with stray requests and completions
        randomize_rom(); random_latencies();
        for (int p = 0; p < NUM_PATTERNS; p++) res_tab[p] = NPE'($urandom & $urandom & $urandom);
        run_campaign("hold_noise", 10, 1'b1, -1);

        // Reset mid-SCAN, then a full campaign
        randomize_rom(); random_latencies();
        for (int p = 0; p < NUM_PATTERNS; p++) res_tab[p] = NPE'($urandom & $urandom);
        run_campaign("reset_mid_scan", 1, 1'b0, 5);
        randomize_rom(); random_latencies();
        for (int p = 0; p < NUM_PATTERNS; p++) res_tab[p] = NPE'($urandom & $urandom & $urandom);
        run_campaign("after_reset", 0, 1'b0, -1);

        // Randomized campaigns
        for (int r = 0; r < 4; r++) begin
            randomize_rom(); random_latencies();
            for (int p = 0; p < NUM_PATTERNS; p++) res_tab[p] = NPE'($urandom & $urandom & $urandom);
            run_campaign($sformatf("random%0d", r), int'($urandom_range(0, 3)), r[0], -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
